spi_bus_arbiter: RTL and testbench

//   Shares the single flash SPI bus (mosi/miso/clk/cs_n) between N requesters (SoC flash controller, LED

---
 rtl/spi_arb_pkg.sv | 32 +++
 rtl/arb_rr_pick.sv | 35 +++
 rtl/spi_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI bus arbiter: FSM encoding, bus payload, index sizing.
package spi_arb_pkg;

  localparam int unsigned MAX_N = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic mosi;
    logic mosi_oe;
    logic clk;
    logic clk_oe;
    logic csn;
  } spi_bus_t;

  // Bus values driven while nobody owns it: CS high, all drivers released.
  function automatic spi_bus_t bus_idle(input logic idle_clk);
    spi_bus_t b;
    b.mosi    = 1'b0;
    b.mosi_oe = 1'b0;
    b.clk     = idle_clk;
    b.clk_oe  = 1'b0;
    b.csn     = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module arb_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     sel,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Two passes: indices from ptr upward, then the wrapped indices below ptr.
  always_comb begin
    sel   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && (k >= 32'(ptr)) && req[k]) begin
        valid  = 1'b1;
        sel[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && (k < 32'(ptr)) && req[k]) begin
        valid  = 1'b1;
        sel[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI flash bus between N requesters: req/gnt handshake, round-robin
// fairness, guard gap with CS high between owners.
// Optional feature macro: SPI_ARB_PREEMPT_EN (hold-time counter driving preempt).
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned N         = 2,
  parameter int unsigned GUARD_CYC = 4,
  parameter logic        IDLE_CLK  = 1'b0,
  parameter int unsigned HOLD_MAX  = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     preempt,
  input  logic [N-1:0]     rq_mosi_o,
  input  logic [N-1:0]     rq_mosi_oe,
  input  logic [N-1:0]     rq_clk_o,
  input  logic [N-1:0]     rq_clk_oe,
  input  logic [N-1:0]     rq_csn_o,
  output logic             spi_mosi_o,
  output logic             spi_mosi_oe,
  output logic             spi_clk_o,
  output logic             spi_clk_oe,
  output logic             spi_csn_o,
  input  logic             spi_miso_i,
  output logic             busy,
  output logic [IDX_W-1:0] owner
);

  localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  arb_state_e       state, state_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [IDX_W-1:0] owner_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [GW-1:0]    guard_cnt, guard_nxt;
  logic [N-1:0]     pick_sel;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             own_req;
  spi_bus_t         bus;

  // MISO is fanned out outside this block; HOLD_MAX only matters with preemption.
  logic unused_ok;
  assign unused_ok = ^{spi_miso_i, HOLD_MAX[0]};

  arb_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .sel   (pick_sel),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign own_req = |(req & gnt);
  assign busy    = (state != ST_IDLE);

  // FSM state and grant bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      owner     <= '0;
      ptr       <= '0;
      guard_cnt <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      guard_cnt <= guard_nxt;
    end
  end

  // Next-state: grant from IDLE, release on owner req drop, count out the guard gap.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    guard_nxt = guard_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_nxt   = pick_sel;
          owner_nxt = pick_idx;
          ptr_nxt   = IDX_W'((32'(pick_idx) + 32'd1) % N);
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!own_req) begin
          gnt_nxt   = '0;
          guard_nxt = GW'(GUARD_CYC - 1);
          state_nxt = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          guard_nxt = guard_cnt - GW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Bus mux: owner's drivers in GRANT (gnt is one-hot there), idle values otherwise.
  always_comb begin
    bus = bus_idle(IDLE_CLK);
    if (state == ST_GRANT) begin
      bus.mosi    = |(rq_mosi_o & gnt);
      bus.mosi_oe = |(rq_mosi_oe & gnt);
      bus.clk     = |(rq_clk_o & gnt);
      bus.clk_oe  = |(rq_clk_oe & gnt);
      bus.csn     = ~|(~rq_csn_o & gnt);
    end
  end

  assign spi_mosi_o  = bus.mosi;
  assign spi_mosi_oe = bus.mosi_oe;
  assign spi_clk_o   = bus.clk;
  assign spi_clk_oe  = bus.clk_oe;
  assign spi_csn_o   = bus.csn;

`ifdef SPI_ARB_PREEMPT_EN
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [N-1:0]  preempt_q, preempt_nxt;
  logic          others_req;

  assign others_req = |(req & ~gnt);

  // Hold-time counter and sticky preempt request toward the current owner.
  always_comb begin
    hold_nxt    = '0;
    preempt_nxt = '0;
    if (state == ST_GRANT) begin
      hold_nxt = hold_cnt;
      if (hold_cnt < HW'(HOLD_MAX)) begin
        hold_nxt = hold_cnt + HW'(1);
      end
      if (own_req && ((preempt_q != '0) || ((hold_cnt >= HW'(HOLD_MAX)) && others_req))) begin
        preempt_nxt = gnt;
      end
    end
  end

  // Preempt counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      preempt_q <= '0;
    end else begin
      hold_cnt  <= hold_nxt;
      preempt_q <= preempt_nxt;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = '0;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter with a transaction-level reference model.
module tb_spi_bus_arbiter;

  localparam int unsigned N         = 2;
  localparam int unsigned GUARD_CYC = 4;
  localparam logic        IDLE_CLK  = 1'b0;
  localparam int unsigned HOLD_MAX  = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] preempt;
  logic [N-1:0] rq_mosi_o, rq_mosi_oe, rq_clk_o, rq_clk_oe, rq_csn_o;
  logic         spi_mosi_o, spi_mosi_oe, spi_clk_o, spi_clk_oe, spi_csn_o;
  logic         spi_miso_i;
  logic         busy;
  logic [2:0]   owner;

  int checks;
  int errors;

  // Reference model: current owner (-1 none), remaining blocked edges, RR start index.
  int m_cur;
  int m_blocked;
  int m_ptr;

  spi_bus_arbiter #(
    .N(N), .GUARD_CYC(GUARD_CYC), .IDLE_CLK(IDLE_CLK), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .preempt(preempt),
    .rq_mosi_o(rq_mosi_o), .rq_mosi_oe(rq_mosi_oe), .rq_clk_o(rq_clk_o),
    .rq_clk_oe(rq_clk_oe), .rq_csn_o(rq_csn_o),
    .spi_mosi_o(spi_mosi_o), .spi_mosi_oe(spi_mosi_oe), .spi_clk_o(spi_clk_o),
    .spi_clk_oe(spi_clk_oe), .spi_csn_o(spi_csn_o), .spi_miso_i(spi_miso_i),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cur     = -1;
    m_blocked = 0;
    m_ptr     = 0;
  endtask

  // One clock edge of arbitration rules, using the req value sampled at the edge.
  task automatic model_edge();
    if (m_cur >= 0) begin
      logic held;
      held = 1'b0;
      for (int i = 0; i < N; i++) if (i == m_cur) held = req[i];
      if (!held) begin
        m_cur     = -1;
        m_blocked = GUARD_CYC;
      end
    end else if (m_blocked > 0) begin
      m_blocked--;
    end else if (req != '0) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (m_cur < 0) begin
          for (int j = 0; j < N; j++) begin
            if (j == k && req[j]) begin
              m_cur = k;
              m_ptr = (k + 1) % N;
            end
          end
        end
      end
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) if (i == m_cur) e[i] = 1'b1;
    return e;
  endfunction

  // Expected bus as {mosi, mosi_oe, clk, clk_oe, csn}.
  function automatic logic [4:0] exp_bus();
    logic [4:0] e;
    e = {1'b0, 1'b0, IDLE_CLK, 1'b0, 1'b1};
    for (int i = 0; i < N; i++) begin
      if (i == m_cur) e = {rq_mosi_o[i], rq_mosi_oe[i], rq_clk_o[i], rq_clk_oe[i], rq_csn_o[i]};
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    rq_mosi_o = N'($urandom); rq_mosi_oe = '1; rq_clk_o = '1; rq_clk_oe = '1; rq_csn_o = '0;
    spi_miso_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, preempt, busy, owner} !== {{N{1'b0}}, {N{1'b0}}, 1'b0, 3'd0}) begin
      errors++; $display("FAIL reset_regs: got gnt=%b pre=%b busy=%b owner=%0d want 0", gnt, preempt, busy, owner);
    end
    checks++;
    if ({spi_mosi_o, spi_mosi_oe, spi_clk_o, spi_clk_oe, spi_csn_o} !== {1'b0, 1'b0, IDLE_CLK, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_bus: got %b want %b", {spi_mosi_o, spi_mosi_oe, spi_clk_o, spi_clk_oe, spi_csn_o},
                         {1'b0, 1'b0, IDLE_CLK, 1'b0, 1'b1});
    end
    tick(); tick();
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if ({gnt, spi_csn_o, spi_mosi_oe, spi_clk_oe, busy} !== {{N{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL idle_after_reset: cyc %0d got gnt=%b csn=%b oe=%b%b busy=%b", c, gnt, spi_csn_o,
                           spi_mosi_oe, spi_clk_oe, busy);
      end
    end
  endtask

  task automatic test_single();
    int n;
    req = 2'b01;
    rq_csn_o = 2'b11;
    tick();
    checks++;
    if ({gnt, busy, owner} !== {2'b01, 1'b1, 3'd0}) begin
      errors++; $display("FAIL single_grant: got gnt=%b busy=%b owner=%0d want 01 1 0", gnt, busy, owner);
    end
    for (int c = 0; c < 6; c++) begin
      rq_csn_o   = {1'($urandom), 1'(c % 2)};
      rq_clk_o   = {1'($urandom), 1'((c / 2) % 2)};
      rq_mosi_o  = N'($urandom);
      rq_mosi_oe = N'($urandom);
      rq_clk_oe  = N'($urandom);
      #1;
      checks++;
      if ({spi_mosi_o, spi_mosi_oe, spi_clk_o, spi_clk_oe, spi_csn_o} !==
          {rq_mosi_o[0], rq_mosi_oe[0], rq_clk_o[0], rq_clk_oe[0], rq_csn_o[0]}) begin
        errors++; $display("FAIL single_mirror: cyc %0d got %b want %b", c,
                           {spi_mosi_o, spi_mosi_oe, spi_clk_o, spi_clk_oe, spi_csn_o},
                           {rq_mosi_o[0], rq_mosi_oe[0], rq_clk_o[0], rq_clk_oe[0], rq_csn_o[0]});
      end
      tick();
    end
    // Drop request while still driving CS low.
    rq_csn_o = 2'b10;
    rq_clk_oe = 2'b11;
    req = 2'b00;
    tick();
    checks++;
    if ({gnt, spi_csn_o, spi_clk_oe} !== {2'b00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_release: got gnt=%b csn=%b clk_oe=%b want 00 1 0", gnt, spi_csn_o, spi_clk_oe);
    end
    n = 0;
    while (busy && n < 20) begin
      checks++;
      if (spi_csn_o !== 1'b1) begin
        errors++; $display("FAIL guard_csn: got %b want 1", spi_csn_o);
      end
      n++;
      tick();
    end
    checks++;
    if (n != GUARD_CYC) begin
      errors++; $display("FAIL guard_len: got %0d want %0d", n, GUARD_CYC);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    int lat;
    do_reset();
    req = 2'b11;
    tick();
    for (int g = 0; g < 4; g++) begin
      want = (g % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (gnt !== want) begin
        errors++; $display("FAIL rr_order: grant %0d got %b want %b", g, gnt, want);
      end
      for (int h = 0; h < 3; h++) begin
        tick();
        checks++;
        if (gnt !== want) begin
          errors++; $display("FAIL rr_hold: grant %0d got %b want %b", g, gnt, want);
        end
      end
      req = 2'b11 & ~gnt;
      tick();
      req = 2'b11;
      lat = 0;
      while (gnt == '0 && lat < 20) begin
        tick();
        lat++;
      end
      checks++;
      if (lat != GUARD_CYC + 1) begin
        errors++; $display("FAIL rr_latency: grant %0d got %0d want %0d", g, lat, GUARD_CYC + 1);
      end
    end
    req = '0;
    repeat (GUARD_CYC + 3) tick();
  endtask

  task automatic test_nonowner();
    do_reset();
    req = 2'b01;
    rq_csn_o = 2'b11; rq_mosi_oe = 2'b00; rq_clk_oe = 2'b00;
    tick();
    req = 2'b11;
    for (int c = 0; c < 8; c++) begin
      rq_csn_o   = {1'(c % 2), 1'b1};
      rq_mosi_oe = {1'($urandom), 1'b0};
      rq_clk_oe  = {1'($urandom), 1'b0};
      #1;
      checks++;
      if ({gnt, spi_csn_o, spi_mosi_oe, spi_clk_oe} !== {2'b01, 1'b1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL nonowner_ignored: cyc %0d got gnt=%b csn=%b oe=%b%b want 01 1 00", c, gnt,
                           spi_csn_o, spi_mosi_oe, spi_clk_oe);
      end
      tick();
    end
    req = '0;
    repeat (GUARD_CYC + 3) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b01;
    tick();
    rq_csn_o = 2'b10; rq_mosi_oe = 2'b01; rq_clk_oe = 2'b01;
    #1;
    checks++;
    if (spi_csn_o !== 1'b0) begin
      errors++; $display("FAIL mid_pre_csn: got %b want 0", spi_csn_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({spi_csn_o, spi_mosi_oe, spi_clk_oe, gnt, busy} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0}) begin
      errors++; $display("FAIL mid_reset: got csn=%b oe=%b%b gnt=%b busy=%b want 1 00 00 0", spi_csn_o,
                         spi_mosi_oe, spi_clk_oe, gnt, busy);
    end
    tick();
    #2;
    rst_n = 1'b1;
    req = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      errors++; $display("FAIL mid_after: got %b want 01", gnt);
    end
    req = '0;
    repeat (GUARD_CYC + 3) tick();
  endtask

  task automatic test_preempt();
    int seen;
    int lat;
    seen = 0;
    do_reset();
    req = 2'b01;
    repeat (5) tick();
    req = 2'b11;
    for (int c = 0; c < 30; c++) begin
      tick();
`ifdef SPI_ARB_PREEMPT_EN
      if (preempt == 2'b01) seen = 1;
`else
      checks++;
      if (preempt !== 2'b00) begin
        errors++; $display("FAIL preempt_off: cyc %0d got %b want 00", c, preempt);
      end
`endif
    end
`ifdef SPI_ARB_PREEMPT_EN
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL preempt_on: got seen=%0d want 1", seen);
    end
`endif
    req = 2'b10;
    tick();
    checks++;
    if ({gnt, preempt} !== {2'b00, 2'b00}) begin
      errors++; $display("FAIL preempt_clear: got gnt=%b pre=%b want 00 00", gnt, preempt);
    end
    lat = 0;
    while (gnt == '0 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (gnt !== 2'b10 || lat != GUARD_CYC + 1) begin
      errors++; $display("FAIL preempt_handover: got gnt=%b lat=%0d want 10 %0d", gnt, lat, GUARD_CYC + 1);
    end
    req = '0;
    repeat (GUARD_CYC + 3) tick();
  endtask

  task automatic test_random();
    logic [4:0] eb;
    do_reset();
    req = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
      rq_mosi_o  = N'($urandom);
      rq_mosi_oe = N'($urandom);
      rq_clk_o   = N'($urandom);
      rq_clk_oe  = N'($urandom);
      rq_csn_o   = N'($urandom);
      spi_miso_i = 1'($urandom);
      #1;
      eb = exp_bus();
      checks++;
      if ({spi_mosi_o, spi_mosi_oe, spi_clk_o, spi_clk_oe, spi_csn_o} !== eb) begin
        errors++; $display("FAIL rand_bus: cyc %0d got %b want %b", c,
                           {spi_mosi_o, spi_mosi_oe, spi_clk_o, spi_clk_oe, spi_csn_o}, eb);
      end
      tick();
      checks++;
      if (gnt !== exp_gnt() || busy !== ((m_cur >= 0) || (m_blocked > 0))) begin
        errors++; $display("FAIL rand_gnt: cyc %0d got gnt=%b busy=%b want gnt=%b busy=%b", c, gnt, busy,
                           exp_gnt(), ((m_cur >= 0) || (m_blocked > 0)));
      end
      if (m_cur >= 0) begin
        checks++;
        if (owner !== 3'(m_cur)) begin
          errors++; $display("FAIL rand_owner: cyc %0d got %0d want %0d", c, owner, m_cur);
        end
      end
`ifndef SPI_ARB_PREEMPT_EN
      checks++;
      if (preempt !== '0) begin
        errors++; $display("FAIL rand_preempt: cyc %0d got %b want 0", c, preempt);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_nonowner();
    test_reset_mid();
    test_preempt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
